// File: rtl/forward_hazard_unit_pkg.sv
// rtl/forward_hazard_unit_pkg.sv - shared forward select codes and register index width
package forward_hazard_unit_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_IDEX  = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

endpackage

// File: rtl/forward_hazard_unit_fwd_select.sv
// rtl/forward_hazard_unit_fwd_select.sv - priority compare producing the forward select for one source
module forward_hazard_unit_fwd_select
  import forward_hazard_unit_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              uses,
  input  logic [ADDR_W-1:0] rs,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [ADDR_W-1:0] mem_rd,
  output logic [1:0]        sel
);

  logic hit_e;
  logic hit_m;

  // x0 is hardwired to zero, so a write to it is never a producer.
  assign hit_e = ex_valid & ex_reg_write & (ex_rd != '0) & (ex_rd == rs);
  assign hit_m = mem_valid & mem_reg_write & (mem_rd != '0) & (mem_rd == rs);

  always_comb begin
    sel = FWD_IDEX;
    if (uses & hit_e) begin
      sel = FWD_EXMEM;
    end else if (uses & hit_m) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// rtl/forward_hazard_unit.sv - registered forward selects, load-use stall and flush handling
module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            ForwardA,
  output logic [1:0]            ForwardB,
  output logic                  ex_valid,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_count
);

  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  mem_valid;
  logic                  mem_reg_write;
  logic [REG_ADDR_W-1:0] mem_rd;

  logic       advance;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  // Only a load still in EX is too young to forward; one cycle later MEM covers it.
  assign stall = id_valid & ~flush & ex_valid & ex_mem_read & (ex_rd != '0) &
                 ((id_uses_rs1 & (ex_rd == id_rs1)) | (id_uses_rs2 & (ex_rd == id_rs2)));

  assign advance = id_valid & ~stall & ~flush;

  forward_hazard_unit_fwd_select #(.ADDR_W(REG_ADDR_W)) u_sel_a (
    .uses          (id_uses_rs1),
    .rs            (id_rs1),
    .ex_valid      (ex_valid),
    .ex_reg_write  (ex_reg_write),
    .ex_rd         (ex_rd),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .sel           (sel_a)
  );

  forward_hazard_unit_fwd_select #(.ADDR_W(REG_ADDR_W)) u_sel_b (
    .uses          (id_uses_rs2),
    .rs            (id_rs2),
    .ex_valid      (ex_valid),
    .ex_reg_write  (ex_reg_write),
    .ex_rd         (ex_rd),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .sel           (sel_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ForwardA      <= FWD_IDEX;
      ForwardB      <= FWD_IDEX;
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_rd         <= '0;
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_rd        <= '0;
      stall_count   <= '0;
    end else begin
      mem_valid     <= ex_valid;
      mem_reg_write <= ex_reg_write;
      mem_rd        <= ex_rd;
      if (advance) begin
        ForwardA     <= sel_a;
        ForwardB     <= sel_b;
        ex_valid     <= 1'b1;
        ex_reg_write <= id_reg_write;
        ex_mem_read  <= id_mem_read;
        ex_rd        <= id_rd;
      end else begin
        ForwardA     <= FWD_IDEX;
        ForwardB     <= FWD_IDEX;
        ex_valid     <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_rd        <= id_rd;
      end
      if (stall && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb/tb_forward_hazard_unit.sv - directed self-checking bench for forward_hazard_unit
module tb_forward_hazard_unit;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        flush;
  logic [1:0]  ForwardA;
  logic [1:0]  ForwardB;
  logic        ex_valid;
  logic        stall;
  logic [31:0] stall_count;

  int checks;
  int errors;

  forward_hazard_unit #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .ForwardA     (ForwardA),
    .ForwardB     (ForwardB),
    .ex_valid     (ex_valid),
    .stall        (stall),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one ID instruction (inputs change just after a rising edge).
  task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic fl);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop_drain();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("reset_fwda", ForwardA, 2'b00);
    check("reset_fwdb", ForwardB, 2'b00);
    check("reset_exv", ex_valid, 1'b0);
    check("reset_stall", stall, 1'b0);
    check("reset_cnt", stall_count, 0);
    rst_n = 1'b1;
    step();

    // add x5,x1,x2 ; sub x6,x5,x3
    issue(1, 1, 2, 1, 1, 5, 1, 0, 0); step();
    issue(1, 5, 3, 1, 1, 6, 1, 0, 0); step();
    check("b2b_fwda", ForwardA, 2'b10);
    check("b2b_fwdb", ForwardB, 2'b00);
    check("b2b_exv", ex_valid, 1'b1);
    nop_drain();

    // add x5 ; nop ; or x7,x3,x5
    issue(1, 1, 2, 1, 1, 5, 1, 0, 0); step();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    issue(1, 3, 5, 1, 1, 7, 1, 0, 0); step();
    check("d2_fwda", ForwardA, 2'b00);
    check("d2_fwdb", ForwardB, 2'b01);
    nop_drain();

    // add x5 ; add x5 ; and x8,x5,x5
    issue(1, 1, 2, 1, 1, 5, 1, 0, 0); step();
    issue(1, 3, 4, 1, 1, 5, 1, 0, 0); step();
    issue(1, 5, 5, 1, 1, 8, 1, 0, 0); step();
    check("dbl_fwda", ForwardA, 2'b10);
    check("dbl_fwdb", ForwardB, 2'b10);
    nop_drain();

    // lw x4,0(x1) ; add x9,x4,x4
    issue(1, 1, 0, 1, 0, 4, 1, 1, 0); step();
    issue(1, 4, 4, 1, 1, 9, 1, 0, 0);
    check("lu_stall", stall, 1'b1);
    step();
    check("lu_bub_exv", ex_valid, 1'b0);
    check("lu_bub_fwda", ForwardA, 2'b00);
    check("lu_bub_fwdb", ForwardB, 2'b00);
    check("lu_cnt", stall_count, 1);
    check("lu_stall_rel", stall, 1'b0);
    step();
    check("lu_fwda", ForwardA, 2'b01);
    check("lu_fwdb", ForwardB, 2'b01);
    check("lu_exv", ex_valid, 1'b1);
    nop_drain();

    // add x0,x1,x2 ; add x3,x0,x0
    issue(1, 1, 2, 1, 1, 0, 1, 0, 0); step();
    issue(1, 0, 0, 1, 1, 3, 1, 0, 0); step();
    check("x0_fwda", ForwardA, 2'b00);
    check("x0_fwdb", ForwardB, 2'b00);
    nop_drain();

    // lw x4 ; addi x9,x4,1 (rs2 field 4, unused)
    issue(1, 1, 0, 1, 0, 4, 1, 1, 0); step();
    issue(1, 4, 4, 1, 0, 9, 1, 0, 0);
    check("imm_stall_rs1", stall, 1'b1);
    step();
    check("imm_cnt", stall_count, 2);
    nop_drain();

    // lw x4 ; addi x10,x11,1 (rs2 field 4, unused)
    issue(1, 1, 0, 1, 0, 4, 1, 1, 0); step();
    issue(1, 11, 4, 1, 0, 10, 1, 0, 0);
    check("imm_nostall", stall, 1'b0);
    step();
    nop_drain();

    // lw x4 ; dependent with flush
    issue(1, 1, 0, 1, 0, 4, 1, 1, 0); step();
    issue(1, 4, 4, 1, 1, 9, 1, 0, 1);
    check("fl_stall", stall, 1'b0);
    step();
    check("fl_exv", ex_valid, 1'b0);
    check("fl_fwda", ForwardA, 2'b00);
    check("fl_cnt", stall_count, 2);
    nop_drain();

    // reset in the middle of a load-use stall
    issue(1, 1, 0, 1, 0, 4, 1, 1, 0); step();
    issue(1, 4, 4, 1, 1, 9, 1, 0, 0);
    check("rst_pre_stall", stall, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_exv", ex_valid, 1'b0);
    check("rst_fwda", ForwardA, 2'b00);
    check("rst_fwdb", ForwardB, 2'b00);
    check("rst_cnt", stall_count, 0);
    step();
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
